// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug RAM access controller: executes JTAG debugger reads and writes against the on-chip debug RAM.
// Optional read-back check after every write is compiled in with `define OCIMEM_WR_VERIFY_EN.
module nios2_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  // state     | meaning
  // S_IDLE    | waiting for a strobe; address loads and range faults complete here
  // S_RD_WAIT | read issued, counting down RAM read latency
  // S_WR      | write strobe on the RAM port
  // S_VERIFY  | read-back of the just-written word (OCIMEM_WR_VERIFY_EN only)
  // S_DONE    | raise monitor_ready, return to idle
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR      = 3'd2,
    S_DONE    = 3'd3
`ifdef OCIMEM_WR_VERIFY_EN
    , S_VERIFY = 3'd4
`endif
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      RD_LAT_L = 2'(RD_LAT);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [31:0]         mon_d_q, mon_d_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;

  logic                out_of_range;
  logic                any_strobe;
  logic [ADDR_W-1:0]   mon_a_inc;
  logic                unused_jdo;

  assign out_of_range = ({1'b0, mon_a_q} >= DEPTH_L);
  assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign mon_a_inc    = mon_a_q + ADDR_W'(1);
  assign unused_jdo   = ^{jdo[37:35], jdo[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mon_a_q <= '0;
      mon_d_q <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    ready_d = ready_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_d = jdo[17 +: ADDR_W];
          err_d   = 1'b0;
          ready_d = 1'b1;
        end else if (take_action_ocimem_b) begin
          if (out_of_range) begin
            err_d   = 1'b1;
            mon_a_d = mon_a_inc;
          end else begin
            mon_d_d = jdo[34:3];
            wdata_d = jdo[34:3];
            addr_d  = mon_a_q;
            we_d    = 1'b1;
            ready_d = 1'b0;
            state_d = S_WR;
          end
        end else if (take_no_action_ocimem_a) begin
          if (out_of_range) begin
            err_d   = 1'b1;
            mon_d_d = 32'hDEAD_DEAD;
            mon_a_d = mon_a_inc;
          end else begin
            addr_d  = mon_a_q;
            re_d    = 1'b1;
            cnt_d   = RD_LAT_L;
            ready_d = 1'b0;
            state_d = S_RD_WAIT;
          end
        end
      end

      // cnt_q reaches zero in the cycle the RAM presents read data
      S_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          mon_d_d = ram_rdata;
          mon_a_d = mon_a_inc;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      S_WR: begin
`ifdef OCIMEM_WR_VERIFY_EN
        re_d    = 1'b1;
        cnt_d   = RD_LAT_L;
        state_d = S_VERIFY;
`else
        mon_a_d = mon_a_inc;
        state_d = S_DONE;
`endif
      end

`ifdef OCIMEM_WR_VERIFY_EN
      S_VERIFY: begin
        if (cnt_q == 2'd0) begin
          if (ram_rdata != mon_d_q) err_d = 1'b1;
          mon_a_d = mon_a_inc;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
`endif

      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // commands arriving mid-operation are dropped and flagged
    if (state_q != S_IDLE && any_strobe) err_d = 1'b1;
  end

  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign ram_we        = we_q;
  assign ram_re        = re_q;
  assign MonAReg       = mon_a_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Directed bench for nios2_debug_ocimem_ctrl: a DEPTH=256 instance with a RAM model,
// plus a DEPTH=200 instance sharing the strobes for range-fault behaviour.
module tb_nios2_debug_ocimem_ctrl;

`ifdef OCIMEM_WR_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 2;
`endif
  localparam int RD_LAT_EXP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0, sn = 1'b0, sb = 1'b0;

  logic [7:0]  ram_addr, mon_a;
  logic [31:0] ram_wdata, ram_rdata, mon_d;
  logic        ram_we, ram_re, ready, error, busy;

  logic [7:0]  d2_ram_addr, d2_mon_a;
  logic [31:0] d2_ram_wdata, d2_mon_d;
  logic        d2_ram_we, d2_ram_re, d2_ready, d2_error, d2_busy;

  logic [31:0] mem [256];
  logic [31:0] rdata_q = '0;
  logic        corrupt = 1'b0;
  logic        preload = 1'b0;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, re_cnt = 0, both_cnt = 0, re200_cnt = 0;
  logic [7:0]  last_we_addr = '0, last_re_addr = '0;
  logic [31:0] last_we_data = '0;

  always #5 clk = ~clk;

  nios2_debug_ocimem_ctrl #(.ADDR_W(8), .DEPTH(256), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(sa), .take_no_action_ocimem_a(sn), .take_action_ocimem_b(sb),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .MonAReg(mon_a), .MonDReg(mon_d),
    .monitor_ready(ready), .monitor_error(error), .busy(busy)
  );

  nios2_debug_ocimem_ctrl #(.ADDR_W(8), .DEPTH(200), .RD_LAT(1)) u_d200 (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(sa), .take_no_action_ocimem_a(sn), .take_action_ocimem_b(sb),
    .ram_addr(d2_ram_addr), .ram_wdata(d2_ram_wdata), .ram_we(d2_ram_we), .ram_re(d2_ram_re),
    .ram_rdata(ram_rdata), .MonAReg(d2_mon_a), .MonDReg(d2_mon_d),
    .monitor_ready(d2_ready), .monitor_error(d2_error), .busy(d2_busy)
  );

  assign ram_rdata = rdata_q;

  always @(posedge clk) begin
    if (preload) begin
      mem[8'h10] <= 32'd1;
      mem[8'h11] <= 32'd2;
      mem[8'h30] <= 32'h1234_5678;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_re) rdata_q <= mem[ram_addr] ^ {31'd0, corrupt};
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        we_cnt++;
        last_we_addr = ram_addr;
        last_we_data = ram_wdata;
      end
      if (ram_re) begin
        re_cnt++;
        last_re_addr = ram_addr;
      end
      if (ram_we && ram_re) both_cnt++;
      if (d2_ram_re) re200_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk_addr(input logic [7:0] a);
    logic [37:0] r;
    r = '0;
    r[24:17] = a;
    return r;
  endfunction

  function automatic logic [37:0] mk_data(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  // called at a negedge; returns at the negedge just after the sampling edge
  task automatic pulse(input logic a, input logic n, input logic b, input logic [37:0] d);
    sa = a; sn = n; sb = b; jdo = d;
    @(posedge clk);
    @(negedge clk);
    sa = 1'b0; sn = 1'b0; sb = 1'b0; jdo = '0;
  endtask

  // edges elapsed since the strobe's sampling edge until monitor_ready is seen
  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  int lat;
  int snap;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mon_a", 32'(mon_a), 32'h0);
    chk("rst_mon_d", mon_d, 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_we_re", 32'({ram_we, ram_re}), 32'h0);
    chk("rst_addr_wdata", ram_wdata | 32'(ram_addr), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // address load then write
    pulse(1, 0, 0, mk_addr(8'h10));
    chk("load_mon_a", 32'(mon_a), 32'h10);
    chk("load_busy", 32'(busy), 32'h0);
    pulse(0, 0, 1, mk_data(32'hA5A5_1234));
    wait_ready(lat);
    chk("wr_latency", 32'(lat), 32'(WR_LAT));
    chk("wr_we_cnt", 32'(we_cnt), 32'd1);
    chk("wr_addr", 32'(last_we_addr), 32'h10);
    chk("wr_data", last_we_data, 32'hA5A5_1234);
    chk("wr_mon_a", 32'(mon_a), 32'h11);
    chk("wr_mon_d", mon_d, 32'hA5A5_1234);
    chk("wr_error", 32'(error), 32'h0);

    // two auto-incrementing reads
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    pulse(1, 0, 0, mk_addr(8'h10));
    pulse(0, 1, 0, '0);
    chk("rd0_busy", 32'(busy), 32'h1);
    wait_ready(lat);
    chk("rd0_latency", 32'(lat), 32'(RD_LAT_EXP));
    chk("rd0_addr", 32'(last_re_addr), 32'h10);
    chk("rd0_mon_d", mon_d, 32'd1);
    pulse(0, 1, 0, '0);
    wait_ready(lat);
    chk("rd1_latency", 32'(lat), 32'(RD_LAT_EXP));
    chk("rd1_mon_d", mon_d, 32'd2);
    chk("rd1_mon_a", 32'(mon_a), 32'h12);

    // out-of-range read on the DEPTH=200 instance
    pulse(1, 0, 0, mk_addr(8'd200));
    snap = re200_cnt;
    pulse(0, 1, 0, '0);
    chk("oor_error", 32'(d2_error), 32'h1);
    chk("oor_mon_d", d2_mon_d, 32'hDEAD_DEAD);
    chk("oor_mon_a", 32'(d2_mon_a), 32'd201);
    chk("oor_ready", 32'(d2_ready), 32'h1);
    chk("oor_busy", 32'(d2_busy), 32'h0);
    wait_ready(lat);
    chk("oor_no_re", 32'(re200_cnt), 32'(snap));
    pulse(1, 0, 0, mk_addr(8'h05));
    chk("oor_clear", 32'(d2_error), 32'h0);

    // write strobe dropped while a read is in flight
    pulse(1, 0, 0, mk_addr(8'h30));
    snap = we_cnt;
    pulse(0, 1, 0, '0);
    pulse(0, 0, 1, mk_data(32'hFFFF_0000));
    wait_ready(lat);
    chk("drop_error", 32'(error), 32'h1);
    chk("drop_mon_d", mon_d, 32'h1234_5678);
    chk("drop_mon_a", 32'(mon_a), 32'h31);
    repeat (2) @(negedge clk);
    chk("drop_no_we", 32'(we_cnt), 32'(snap));

    // address wrap on write, then simultaneous load + write
    pulse(1, 0, 0, mk_addr(8'hFF));
    chk("wrap_err_clr", 32'(error), 32'h0);
    pulse(0, 0, 1, mk_data(32'hDEAD_0001));
    wait_ready(lat);
    chk("wrap_latency", 32'(lat), 32'(WR_LAT));
    chk("wrap_addr", 32'(last_we_addr), 32'hFF);
    chk("wrap_mon_a", 32'(mon_a), 32'h00);
    snap = we_cnt;
    pulse(1, 0, 1, mk_addr(8'h42) | mk_data(32'h0000_0007));
    chk("prio_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    chk("prio_mon_a", 32'(mon_a), 32'h42);
    chk("prio_mon_d", mon_d, 32'hDEAD_0001);
    chk("prio_no_we", 32'(we_cnt), 32'(snap));
    chk("prio_error", 32'(error), 32'h0);

`ifdef OCIMEM_WR_VERIFY_EN
    // read-back mismatch on a corrupting RAM
    corrupt = 1'b1;
    pulse(1, 0, 0, mk_addr(8'h50));
    pulse(0, 0, 1, mk_data(32'h0000_0001));
    wait_ready(lat);
    chk("vfy_latency", 32'(lat), 32'd4);
    chk("vfy_error", 32'(error), 32'h1);
    chk("vfy_mon_a", 32'(mon_a), 32'h51);
    corrupt = 1'b0;
`endif

    // reset in the middle of a read discards the result
    pulse(1, 0, 0, mk_addr(8'h10));
    pulse(0, 1, 0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h1);
    chk("mid_rst_mon_a", 32'(mon_a), 32'h0);
    repeat (3) @(negedge clk);
    chk("mid_rst_mon_d", mon_d, 32'h0);
    chk("mid_rst_we", 32'(ram_we), 32'h0);

    chk("we_re_overlap", 32'(both_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
